// File: rtl/gbuff_stream_reader.sv
// gbuff_stream_reader
//   Reads a strided sequence of words from the global buffer and presents
//   them as a valid/ready stream through a 2-entry FIFO.
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  launch a transfer (honoured in IDLE only)
//   base_addr/stride/count transfer parameters, sampled with start
//   busy, done             status; done is a one-cycle pulse
//   gb_wr_en               buffer write enable, always 0
//   gb_index, gb_rd        buffer read request (index is registered)
//   gb_data_out            buffer read data, valid the cycle after gb_rd
//   m_valid/m_ready/m_data output stream, m_data is the FIFO head
module gbuff_stream_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              gb_wr_en,
  output logic [ADDR_W-1:0] gb_index,
  output logic              gb_rd,
  input  logic [DATA_W-1:0] gb_data_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [ADDR_W:0]   issued_q, issued_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              infl_q, infl_d;

  logic [DATA_W-1:0] fifo_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        occ_q;

  logic pop, push, credit, issue;

  assign pop  = (occ_q != 2'd0) & m_ready;
  assign push = infl_q;
  // The request is decided and presented in the same cycle, so only the
  // previous cycle's request is still in flight; counting it with the
  // current pop keeps the FIFO from overflowing while allowing 1 word/cycle.
  assign credit = ({1'b0, occ_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop});
  assign issue  = (state_q == S_READ) & credit;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    stride_d = stride_q;
    issued_d = issued_q;
    idx_d    = idx_q;
    infl_d   = issue;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d  = count;
          stride_d = stride;
          issued_d = '0;
          if (count != '0) begin
            idx_d   = base_addr;
            state_d = S_READ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        if (issue) begin
          issued_d = issued_q + 1'b1;
          // Index advances only while more requests remain, so it holds the
          // last issued address afterwards.
          if (issued_q + 1'b1 == count_q) state_d = S_DRAIN;
          else                            idx_d   = idx_q + stride_q;
        end
      end
      S_DRAIN: begin
        if ((occ_q == 2'd0) && !infl_q) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      stride_q <= '0;
      issued_q <= '0;
      idx_q    <= '0;
      infl_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      stride_q <= stride_d;
      issued_q <= issued_d;
      idx_q    <= idx_d;
      infl_q   <= infl_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= gb_data_out;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign gb_wr_en = 1'b0;
  assign gb_rd    = issue;
  assign gb_index = idx_q;
  assign m_valid  = (occ_q != 2'd0);
  assign m_data   = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_gbuff_stream_reader.sv
// Directed testbench for gbuff_stream_reader. A registered buffer model
// returns buffer[i] = i + 100 one cycle after each request.
module tb_gbuff_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr, stride;
  logic [8:0]  count;
  logic        busy, done, gb_wr_en, gb_rd, m_valid, m_ready;
  logic [7:0]  gb_index;
  logic [31:0] gb_data_out = '0;
  logic [31:0] m_data;

  gbuff_stream_reader #(.DATA_W(32), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .stride(stride), .count(count), .busy(busy), .done(done),
    .gb_wr_en(gb_wr_en), .gb_index(gb_index), .gb_rd(gb_rd),
    .gb_data_out(gb_data_out), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (gb_rd) gb_data_out <= 32'(gb_index) + 32'd100;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [31:0] v; } ev_t;
  ev_t rd_q[$];
  ev_t pop_q[$];
  int  done_cnt, done_cyc;
  bit  wr_seen, mv_seen, occ_bad;
  int  occ_m, rd_h1, rd_h2, pop_h1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: samples mid-cycle and tracks the FIFO occupancy implied by the
  // request/pop history (data lands two sampling points after its request).
  always @(negedge clk) begin
    if (!rst_n) begin
      occ_m = 0; rd_h1 = 0; rd_h2 = 0; pop_h1 = 0;
    end else begin
      occ_m = occ_m + rd_h2 - pop_h1;
      if (occ_m > 2 || occ_m < 0 || m_valid !== (occ_m != 0)) occ_bad = 1;
      if (gb_rd) rd_q.push_back('{cyc, 32'(gb_index)});
      if (m_valid && m_ready) pop_q.push_back('{cyc, m_data});
      if (m_valid) mv_seen = 1;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (gb_wr_en) wr_seen = 1;
      rd_h2 = rd_h1; rd_h1 = int'(gb_rd); pop_h1 = int'(m_valid && m_ready);
    end
  end

  bit toggle_mode = 0;
  logic pat [4];
  initial begin
    int n = 0;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (toggle_mode) begin m_ready = pat[n % 4]; n++; end
    end
  end

  task automatic clear_logs();
    rd_q.delete(); pop_q.delete();
    done_cnt = 0; done_cyc = -1; mv_seen = 0; occ_bad = 0;
  endtask

  task automatic start_xfer(input logic [7:0] b, input logic [7:0] s,
                            input logic [8:0] c, output int k);
    @(posedge clk); #1;
    clear_logs();
    start = 1'b1; base_addr = b; stride = s; count = c;
    @(posedge clk); #1;
    start = 1'b0;
    k = cyc;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk); #1;
      if (done) seen = 1;
    end
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({tag, " busy_with_done"}, 64'(busy), 64'd1);
      @(negedge clk); #1;
      check({tag, " done_falls"}, 64'(done), 64'd0);
      check({tag, " busy_falls"}, 64'(busy), 64'd0);
    end
    repeat (3) @(negedge clk);
    #1;
    check({tag, " done_once"}, 64'(done_cnt), 64'd1);
    check({tag, " occupancy_ok"}, 64'(occ_bad), 64'd0);
  endtask

  task automatic check_stream(input string tag, input int n, input int base,
                              input int str, input int k, input bit timed);
    check({tag, " n_reads"}, 64'(rd_q.size()), 64'(n));
    check({tag, " n_words"}, 64'(pop_q.size()), 64'(n));
    for (int i = 0; i < n && i < rd_q.size(); i++)
      check($sformatf("%s idx%0d", tag, i), 64'(rd_q[i].v), 64'((base + i * str) % 256));
    for (int i = 0; i < n && i < pop_q.size(); i++)
      check($sformatf("%s word%0d", tag, i), 64'(pop_q[i].v), 64'((base + i * str) % 256 + 100));
    if (timed && rd_q.size() > 0) check({tag, " first_rd_cyc"}, 64'(rd_q[0].cyc - k), 64'd0);
    if (timed)
      for (int i = 0; i < n && i < pop_q.size(); i++)
        check($sformatf("%s word%0d_cyc", tag, i), 64'(pop_q[i].cyc - k), 64'(2 + i));
  endtask

  initial begin
    int k;
    bit got3;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; stride = '0; count = '0; m_ready = 1'b1;
    wr_seen = 0;
    clear_logs();
    repeat (3) @(posedge clk);
    #2;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst m_valid", 64'(m_valid), 64'd0);
    check("rst gb_rd", 64'(gb_rd), 64'd0);
    check("rst gb_index", 64'(gb_index), 64'd0);
    check("rst m_data", 64'(m_data), 64'd0);
    @(negedge clk); #1 rst_n = 1'b1;

    // Basic sequential read with back-to-back stream acceptance
    start_xfer(8'd0, 8'd1, 9'd4, k);
    wait_done("seq");
    check_stream("seq", 4, 0, 1, k, 1'b1);

    // Index wrap
    start_xfer(8'd250, 8'd3, 9'd4, k);
    wait_done("wrap");
    check_stream("wrap", 4, 250, 3, k, 1'b1);

    // Back-pressure 1,0,0,1
    toggle_mode = 1;
    start_xfer(8'd10, 8'd1, 9'd8, k);
    wait_done("bp");
    check_stream("bp", 8, 10, 1, k, 1'b0);
    toggle_mode = 0;
    @(posedge clk); #1 m_ready = 1'b1;

    // Zero-length transfer
    start_xfer(8'd7, 8'd1, 9'd0, k);
    wait_done("zero");
    check("zero done_cyc", 64'(done_cyc - k), 64'd0);
    check("zero n_reads", 64'(rd_q.size()), 64'd0);
    check("zero m_valid_seen", 64'(mv_seen), 64'd0);

    // Start pulsed mid-transfer with different parameters
    start_xfer(8'd20, 8'd2, 9'd8, k);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'd99; stride = 8'd7; count = 9'd1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("restart");
    check_stream("restart", 8, 20, 2, k, 1'b1);

    // Reset mid-transfer, then a fresh transfer on the first edge
    start_xfer(8'd0, 8'd1, 9'd16, k);
    got3 = 0;
    for (int i = 0; i < 100 && !got3; i++) begin
      @(negedge clk); #1;
      if (pop_q.size() >= 3) got3 = 1;
    end
    check("mid three_words", 64'(got3), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid busy", 64'(busy), 64'd0);
    check("mid done", 64'(done), 64'd0);
    check("mid m_valid", 64'(m_valid), 64'd0);
    check("mid gb_rd", 64'(gb_rd), 64'd0);
    check("mid gb_index", 64'(gb_index), 64'd0);
    check("mid m_data", 64'(m_data), 64'd0);
    check("mid gb_wr_en", 64'(gb_wr_en), 64'd0);
    @(negedge clk); #1;
    clear_logs();
    rst_n = 1'b1; start = 1'b1; base_addr = 8'd5; stride = 8'd1; count = 9'd2;
    @(posedge clk); #1 start = 1'b0;
    k = cyc;
    wait_done("post_rst");
    check_stream("post_rst", 2, 5, 1, k, 1'b1);

    check("gb_wr_en never", 64'(wr_seen), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gbuff_stream_reader.md
GBUFF_STREAM_READER -- requirements
Module: gbuff_stream_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the global buffer word width.
REQ-002 SHALL have parameter ADDR_W, default 8, giving the global buffer index width (256 words).
REQ-003 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: launches one transfer when sampled high in IDLE.
REQ-006 SHALL have port base_addr, input, ADDR_W bits: first buffer index; sampled with start.
REQ-007 SHALL have port stride, input, ADDR_W bits: index increment per word; sampled with start.
REQ-008 SHALL have port count, input, ADDR_W+1 bits: number of words, 0..256; sampled with start.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at transfer completion.
REQ-011 SHALL have port gb_wr_en, output, 1 bit: buffer write enable; tied 0 (this block is read-only).
REQ-012 SHALL have port gb_index, output, ADDR_W bits: buffer read index, registered.
REQ-013 SHALL have port gb_rd, output, 1 bit: high in each cycle where gb_index carries a new read request.
REQ-014 SHALL have port gb_data_out, input, DATA_W bits: buffer read data, valid the cycle after the request.
REQ-015 SHALL have port m_valid, output, 1 bit: stream data valid.
REQ-016 SHALL have port m_ready, input, 1 bit: downstream accepts when high together with m_valid.
REQ-017 SHALL have port m_data, output, DATA_W bits: stream word, driven from FIFO head.

Function
REQ-018 SHALL implement FSM states IDLE, READ, DRAIN, and DONE.
REQ-019 SHALL go IDLE->READ when start=1 and count!=0; SHALL go IDLE->DONE when start=1 and count=0, issuing no reads.
REQ-020 SHALL ignore start in every state other than IDLE; latched parameters SHALL stay unchanged during a transfer.
REQ-021 SHALL generate the i-th request address as (base_addr + i*stride) mod 2^ADDR_W, for i = 0..count-1, wrapping silently.
REQ-022 SHALL treat the buffer as having one-cycle read latency: a request in cycle C is captured from gb_data_out at the end of cycle C+1.
REQ-023 SHALL hold read data in a 2-entry FIFO; m_valid SHALL equal FIFO non-empty and m_data SHALL equal the FIFO head.
REQ-024 SHALL issue a request in READ only when (occupancy + in-flight - pop) < 2, where pop = m_valid & m_ready; no word SHALL ever be dropped or duplicated.
REQ-025 SHALL sustain one word per cycle while m_ready stays high.
REQ-026 SHALL move READ->DRAIN in the cycle after the count-th request issues.
REQ-027 SHALL move DRAIN->DONE when the FIFO is empty and no request is in flight.
REQ-028 SHALL assert done for exactly one cycle in DONE, then return to IDLE; busy SHALL be low in IDLE only.
REQ-029 SHALL, when start is sampled at edge k with count>=1 and m_ready=1, present gb_index=base_addr with gb_rd=1 after edge k, and assert m_valid with word 0 after edge k+2.
REQ-030 SHALL hold gb_index at its last value when gb_rd=0; gb_wr_en SHALL never be 1.
REQ-031 SHALL deliver words to the stream in request order.

Reset
REQ-032 SHALL, on rst_n low at any time including mid-transfer, immediately force: FSM=IDLE; FIFO and in-flight count cleared; busy=0; done=0; m_valid=0; gb_rd=0; gb_index=0; gb_wr_en=0; m_data=0.
REQ-033 SHALL, after rst_n is released, accept start on the first rising edge.

Verification
REQ-034 Bench SHALL check: buffer[i]=i+100, start with base=0, stride=1, count=4, m_ready=1 -> m_data 100,101,102,103 on consecutive cycles, first m_valid 2 cycles after start, done once, busy falls with done.
REQ-035 Bench SHALL check: base=250, stride=3, count=4 -> indices 250,253,0,3 (wrap).
REQ-036 Bench SHALL check: count=8 with m_ready toggling 1,0,0,1 repeatedly -> all 8 words delivered in order with none lost or duplicated; FIFO never exceeds 2 entries.
REQ-037 Bench SHALL check: start with count=0 -> done pulses 1 cycle after start, gb_rd never asserted, m_valid never asserted.
REQ-038 Bench SHALL check: start pulsed again mid-transfer -> ignored, transfer unchanged.
REQ-039 Bench SHALL check: rst_n asserted after 3 words of count=16 -> all outputs 0 immediately; a new start with count=2 then completes normally.
